// File: rtl/cpu6_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_lsu_if
//  Description : Request/response and data-memory bus bundle for cpu6_lsu.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

interface cpu6_lsu_if #(
    parameter int XLEN = `CPU6_XLEN
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_split;
    logic            resp_err;

    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    // LSU side: consumes requests and read data, drives responses and the RAM port.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_split, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_split, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cpu6_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_lsu
//  Description : Little-endian load/store unit; splits word-straddling accesses
//                into two word transactions on a 1-cycle-latency RAM port.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module cpu6_lsu #(
    parameter int XLEN = `CPU6_XLEN
) (
    input  wire logic    clk,
    input  wire logic    reset,
    cpu6_lsu_if.slave    bus
);

    localparam logic [1:0] c_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] c_SIZE_HALF    = 2'b01;
    localparam logic [1:0] c_SIZE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_LAST = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_split;
    logic            r_resp_err;
    logic [XLEN-1:0] r_resp_rdata;

    logic            r_we;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_word0;

    logic [1:0]        w_off;
    logic [2:0]        w_nbytes;
    logic [7:0]        w_nmask;
    logic              w_split;
    logic [7:0]        w_mask;
    logic [2*XLEN-1:0] w_lanes;
    logic [XLEN-1:0]   w_word0_addr;
    logic [XLEN-1:0]   w_word1_addr;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_merged;
    logic [XLEN-1:0]   w_load_data;

    assign w_off = r_addr[1:0];

    always_comb begin
        w_nbytes = 3'd4;
        w_nmask  = 8'h0F;
        case (r_size)
            c_SIZE_BYTE: begin
                w_nbytes = 3'd1;
                w_nmask  = 8'h01;
            end
            c_SIZE_HALF: begin
                w_nbytes = 3'd2;
                w_nmask  = 8'h03;
            end
            default: begin
                w_nbytes = 3'd4;
                w_nmask  = 8'h0F;
            end
        endcase
    end

    assign w_split      = (({1'b0, w_off} + w_nbytes) > 3'd4);
    assign w_mask       = w_nmask << w_off;
    assign w_lanes      = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_word0_addr = {r_addr[XLEN-1:2], 2'b00};
    assign w_word1_addr = w_word0_addr + XLEN'(4);

    // In LAST the RAM returns the final word: word0 when unsplit, word1 when split.
    assign w_lo     = w_split ? r_word0 : bus.mem_rdata;
    assign w_merged = XLEN'({bus.mem_rdata, w_lo} >> {w_off, 3'b000});

    always_comb begin
        w_load_data = w_merged;
        case (r_size)
            c_SIZE_BYTE:
                w_load_data = {{(XLEN-8){w_merged[7] & ~r_unsigned}}, w_merged[7:0]};
            c_SIZE_HALF:
                w_load_data = {{(XLEN-16){w_merged[15] & ~r_unsigned}}, w_merged[15:0]};
            default:
                w_load_data = w_merged;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_split <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word0      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (bus.req_size == c_SIZE_ILLEGAL) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_split <= 1'b0;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    r_state <= w_split ? S_ACC1 : S_LAST;
                end
                S_ACC1: begin
                    r_word0 <= bus.mem_rdata;
                    r_state <= S_LAST;
                end
                S_LAST: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_split <= w_split;
                    r_resp_rdata <= r_we ? '0 : w_load_data;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_split <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_ACC0: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_be    = w_mask[3:0];
                bus.mem_addr  = w_word0_addr;
                bus.mem_wdata = r_we ? w_lanes[XLEN-1:0] : '0;
            end
            S_ACC1: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_be    = w_mask[7:4];
                bus.mem_addr  = w_word1_addr;
                bus.mem_wdata = r_we ? w_lanes[2*XLEN-1:XLEN] : '0;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_split = r_resp_split;
    assign bus.resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu6_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu6_lsu
//  Description : Directed self-checking bench for cpu6_lsu with a 1-cycle RAM.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_cpu6_lsu;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu6_lsu_if #(.XLEN(32)) bus();

    cpu6_lsu #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous RAM, one-cycle read latency, byte-enable writes.
    logic [31:0] mem [logic [29:0]];

    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.mem_req) begin
            w = mem.exists(bus.mem_addr[31:2]) ? mem[bus.mem_addr[31:2]] : 32'h0;
            bus.mem_rdata <= w;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                mem[bus.mem_addr[31:2]] = w;
            end
        end
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int          nmem;
    int          lat;
    logic        idle_dirty;
    logic [31:0] la  [4];
    logic [31:0] lwd [4];
    logic [3:0]  lbe [4];
    logic        lwe [4];
    logic [31:0] got_rdata;
    logic        got_split;
    logic        got_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record_mem();
        if (bus.mem_req) begin
            if (nmem < 4) begin
                la[nmem]  = bus.mem_addr;
                lwd[nmem] = bus.mem_wdata;
                lbe[nmem] = bus.mem_be;
                lwe[nmem] = bus.mem_we;
            end
            nmem++;
        end else if (bus.mem_we || bus.mem_be != 4'b0 || bus.mem_addr != 32'h0 ||
                     bus.mem_wdata != 32'h0) begin
            idle_dirty = 1'b1;
        end
    endtask

    // Issue one request, log RAM traffic, capture the response and its cycle index.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int  guard;
        bit  got;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 1'b0;
        nmem = 0;
        lat = 0;
        idle_dirty = 1'b0;
        got = 1'b0;
        while (!got && lat < 12) begin
            lat++;
            record_mem();
            if (bus.resp_valid === 1'b1) begin
                got = 1'b1;
                got_rdata = bus.resp_rdata;
                got_split = bus.resp_split;
                got_err   = bus.resp_err;
            end else begin
                tick();
            end
        end
        if (!got) lat = 99;
        tick();
        chk({tag, "_pulse"}, {30'b0, bus.resp_valid, bus.req_ready}, 32'h1);
        chk({tag, "_memidle"}, {31'b0, idle_dirty}, 32'h0);
    endtask

    initial begin
        bit seen;

        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        mem[30'h040]      = 32'h80207A20;   // 0x100
        mem[30'h041]      = 32'h44332211;   // 0x104
        mem[30'h3FFFFFFF] = 32'h9C000000;   // 0xFFFFFFFC
        mem[30'h000]      = 32'h55667788;   // 0x00000000

        tick();
        tick();
        chk("rst_ctrl", {27'b0, bus.req_ready, bus.mem_req, bus.mem_we, bus.resp_valid,
                         bus.resp_err}, 32'h10);
        chk("rst_mem", {bus.mem_addr[31:4], bus.mem_be} | bus.mem_wdata, 32'h0);
        chk("rst_resp", bus.resp_rdata | {31'b0, bus.resp_split}, 32'h0);
        reset = 1'b0;
        tick();

        do_req("lh100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        chk("lh100_data", got_rdata, 32'h00007A20);
        chk("lh100_meta", {lat[7:0], 6'b0, got_split, got_err, 7'b0, lwe[0], 4'b0, lbe[0], nmem[7:0]},
            {8'd3, 6'b0, 1'b0, 1'b0, 7'b0, 1'b0, 4'b0, 4'b0011, 8'd1});
        chk("lh100_addr", la[0], 32'h100);

        do_req("lh102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        chk("lh102_data", got_rdata, 32'hFFFF8020);
        chk("lh102_meta", {lat[7:0], 7'b0, got_split, 12'b0, lbe[0], nmem[7:0]},
            {8'd3, 7'b0, 1'b0, 12'b0, 4'b1100, 8'd1});

        do_req("lhu102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        chk("lhu102_data", got_rdata, 32'h00008020);
        chk("lhu102_meta", {lat[7:0], 7'b0, got_split, 8'b0, nmem[7:0]},
            {8'd3, 7'b0, 1'b0, 8'b0, 8'd1});

        do_req("lw103", 1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        chk("lw103_data", got_rdata, 32'h33221180);
        chk("lw103_meta", {lat[7:0], 7'b0, got_split, lbe[1], lbe[0], nmem[7:0]},
            {8'd4, 7'b0, 1'b1, 4'b0111, 4'b1000, 8'd2});
        chk("lw103_addr0", la[0], 32'h100);
        chk("lw103_addr1", la[1], 32'h104);

        do_req("sh107", 1'b1, 2'b01, 1'b0, 32'h107, 32'h0000BEEF);
        chk("sh107_meta", {6'b0, lwe[1], lwe[0], 7'b0, got_split, lbe[1], lbe[0], nmem[7:0]},
            {6'b0, 1'b1, 1'b1, 7'b0, 1'b1, 4'b0001, 4'b1000, 8'd2});
        chk("sh107_addr0", la[0], 32'h104);
        chk("sh107_wd0", lwd[0], 32'hEF000000);
        chk("sh107_addr1", la[1], 32'h108);
        chk("sh107_wd1", lwd[1], 32'h000000BE);
        chk("sh107_rdata", got_rdata, 32'h0);

        do_req("lhu107", 1'b0, 2'b01, 1'b1, 32'h107, 32'h0);
        chk("lhu107_data", got_rdata, 32'h0000BEEF);
        chk("lhu107_split", {31'b0, got_split}, 32'h1);

        do_req("lbFFF", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0);
        chk("lbFFF_data", got_rdata, 32'hFFFFFF9C);
        chk("lbFFF_meta", {7'b0, got_split, lbe[0], 4'b0, nmem[7:0], lat[7:0]},
            {7'b0, 1'b0, 4'b1000, 4'b0, 8'd1, 8'd3});
        chk("lbFFF_addr", la[0], 32'hFFFFFFFC);

        do_req("lwFFE", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
        chk("lwFFE_data", got_rdata, 32'h77889C00);
        chk("lwFFE_addr0", la[0], 32'hFFFFFFFC);
        chk("lwFFE_addr1", la[1], 32'h00000000);
        chk("lwFFE_meta", {7'b0, got_split, lbe[1], lbe[0], nmem[7:0], lat[7:0]},
            {7'b0, 1'b1, 4'b0011, 4'b1100, 8'd2, 8'd4});

        do_req("ill", 1'b0, 2'b11, 1'b0, 32'h104, 32'h0);
        chk("ill_meta", {6'b0, got_err, got_split, nmem[7:0], 8'b0, lat[7:0]},
            {6'b0, 1'b1, 1'b0, 8'd0, 8'b0, 8'd1});
        chk("ill_rdata", got_rdata, 32'h0);

        do_req("sw200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
        chk("sw200_meta", {6'b0, got_err, got_split, 3'b0, lwe[0], lbe[0], nmem[7:0], lat[7:0]},
            {6'b0, 1'b0, 1'b0, 3'b0, 1'b1, 4'b1111, 8'd1, 8'd3});
        chk("sw200_addr", la[0], 32'h200);
        chk("sw200_wd", lwd[0], 32'h12345678);

        do_req("lw200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        chk("lw200_data", got_rdata, 32'h12345678);

        // Abort a split load in its second RAM cycle.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr  = 32'h103;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("abort_acc1", {bus.mem_addr[31:1], bus.mem_req}, {31'(32'h104 >> 1), 1'b1});
        #1 reset = 1'b1;
        #1;
        chk("abort_ctrl", {27'b0, bus.req_ready, bus.mem_req, bus.mem_we, bus.resp_valid,
                           bus.resp_err}, 32'h10);
        chk("abort_mem", bus.mem_addr | bus.mem_wdata | {28'b0, bus.mem_be}, 32'h0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("abort_quiet", {31'b0, seen}, 32'h0);

        do_req("post_lh", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        chk("post_lh_data", got_rdata, 32'h00007A20);
        chk("post_lh_lat", lat, 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
